// File: rtl/jam_pkg.sv
// Shared widths and the controller state encoding for the JAM cost server.
package jam_pkg;

    localparam int COST_W = 7;   // one cost-table entry
    localparam int MIN_W  = 10;  // requester minimum-cost result
    localparam int CNT_W  = 4;   // requester match-count result
    localparam int IDX_W  = 6;   // flat table index, 8*W + J
    localparam int N      = 8;   // workers == jobs
    localparam int SEL_W  = 3;   // width of one W or J index

    typedef enum logic [1:0] {
        LOAD,
        SERVE,
        DONE
    } state_t;

endpackage

// File: rtl/jam_cost_mem.sv
// 64 x 7 cost table: one write port, one registered read port, no reset.
module jam_cost_mem
    import jam_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [COST_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [COST_W-1:0] rd_data
);

    logic [COST_W-1:0] mem_q [N*N];
    logic [COST_W-1:0] rd_data_q;

    // Table write and synchronous read; a same-address read returns the old entry.
    // NOTE: storage carries no reset so it maps onto plain RAM; the table is reloaded after every reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/jam_cost_server.sv
// Cost-table server for a JAM requester: loads 64 costs, answers {W,J}
// lookups with one cycle of latency, then checks the requester's result
// against golden values once.
module jam_cost_server
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [COST_W-1:0] LD_DATA,
    input  logic [SEL_W-1:0]  W,
    input  logic [SEL_W-1:0]  J,
    output logic [COST_W-1:0] Cost,
    input  logic              Valid,
    input  logic [MIN_W-1:0]  MinCost,
    input  logic [CNT_W-1:0]  MatchCount,
    input  logic [MIN_W-1:0]  EXP_MINCOST,
    input  logic [CNT_W-1:0]  EXP_MATCHCOUNT,
    output logic              SERVING,
    output logic              DONE,
    output logic              PASS
);

    // The port DONE shadows the state literal, so the literal is always package-qualified.
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               wr_en;
    logic [COST_W-1:0]  rd_cost;
    logic               result_match;

    // Full-width unsigned compare against the golden values.
    assign result_match = (MinCost == EXP_MINCOST) && (MatchCount == EXP_MATCHCOUNT);

    // Only LOAD-state beats reach the table; later LD_VALID traffic is dropped.
    assign wr_en = (state_q == LOAD) && LD_VALID;

    jam_cost_mem u_mem (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (idx_q),
        .wr_data (LD_DATA),
        .rd_addr ({W, J}),
        .rd_data (rd_cost)
    );

    // Next-state logic: load counter, serve, one-shot result capture.
    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            LOAD: begin
                if (LD_VALID) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N*N - 1)) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                if (Valid) begin
                    pass_d  = result_match;
                    done_d  = 1'b1;
                    state_d = jam_pkg::DONE;
                end
            end
            default: begin
                // Result already captured; hold until reset.
            end
        endcase
    end

    // State, load index and result flags; all cleared by the asynchronous reset.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= LOAD;
            idx_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign LD_READY = (state_q == LOAD);
    assign SERVING  = (state_q != LOAD);
    assign DONE     = done_q;
    assign PASS     = pass_q;
    // Registered table output, forced to zero while loading or in reset.
    assign Cost     = SERVING ? rd_cost : '0;

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: scoreboarded Cost lookups,
// load handshake with gaps, result capture and asynchronous reset.
module tb_jam_cost_server;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [6:0]  ld_data;
    logic [2:0]  w;
    logic [2:0]  j;
    logic [6:0]  cost;
    logic        valid;
    logic [9:0]  min_cost;
    logic [3:0]  match_count;
    logic [9:0]  exp_min_cost;
    logic [3:0]  exp_match_count;
    logic        serving;
    logic        done;
    logic        pass;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [6:0]  vals  [64];   // matrix offered by the next load
    logic [6:0]  model [64];   // matrix the DUT should currently hold
    logic [6:0]  exp_q [$];    // expected Cost values, oldest first

    jam_cost_server dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .LD_VALID       (ld_valid),
        .LD_READY       (ld_ready),
        .LD_DATA        (ld_data),
        .W              (w),
        .J              (j),
        .Cost           (cost),
        .Valid          (valid),
        .MinCost        (min_cost),
        .MatchCount     (match_count),
        .EXP_MINCOST    (exp_min_cost),
        .EXP_MATCHCOUNT (exp_match_count),
        .SERVING        (serving),
        .DONE           (done),
        .PASS           (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Assert reset mid-cycle, confirm the outputs react at once, then release.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ld_ready", int'(ld_ready), 1);
        check("rst_serving",  int'(serving),  0);
        check("rst_done",     int'(done),     0);
        check("rst_pass",     int'(pass),     0);
        check("rst_cost",     int'(cost),     0);
        ld_valid = 1'b0;
        valid    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic fill_mod100();
        for (int k = 0; k < 64; k++) vals[k] = 7'(k % 100);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) vals[k] = 7'($urandom_range(0, 127));
    endtask

    // Offer vals[] beat by beat. Optional gap every third cycle, optional
    // Valid pulse on one beat, optional reset in place of one beat.
    task automatic load_matrix(input bit use_gaps, input int valid_beat, input int abort_beat);
        int b = 0;
        int c = 0;
        while (b < 64 && c < 400) begin
            ld_valid = !(use_gaps && (c % 3 == 2));
            ld_data  = vals[b];
            w        = 3'($urandom_range(0, 7));
            j        = 3'($urandom_range(0, 7));
            valid    = ld_valid && (b == valid_beat);
            if (ld_valid && b == abort_beat) begin
                apply_reset();
                return;
            end
            check("ld_ready_load", int'(ld_ready), 1);
            check("serving_load",  int'(serving),  0);
            check("cost_load",     int'(cost),     0);
            @(posedge clk);
            #1;
            if (ld_valid) b++;
            c++;
        end
        ld_valid = 1'b0;
        valid    = 1'b0;
        check("load_beats",        b,               64);
        check("serving_after_load", int'(serving),  1);
        check("ld_ready_after",    int'(ld_ready),  0);
        check("done_after_load",   int'(done),      0);
        for (int k = 0; k < 64; k++) model[k] = vals[k];
    endtask

    // One lookup: push the expected entry, step a cycle, pop and compare.
    // LD_VALID is held high with junk data to show the table ignores it.
    task automatic read_cost(input logic [2:0] wi, input logic [2:0] ji);
        logic [6:0] exp_cost;
        w        = wi;
        j        = ji;
        ld_valid = 1'b1;
        ld_data  = 7'($urandom_range(0, 127));
        exp_q.push_back(model[{wi, ji}]);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        exp_cost = exp_q.pop_front();
        check($sformatf("cost_w%0d_j%0d", wi, ji), int'(cost), int'(exp_cost));
        check("ld_ready_serve", int'(ld_ready), 0);
    endtask

    task automatic random_reads(input int n);
        for (int k = 0; k < n; k++) begin
            read_cost(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end
    endtask

    // One-cycle Valid pulse with the given result and golden values.
    task automatic pulse_valid(input string tag, input int mc, input int cnt,
                               input int emc, input int ecnt,
                               input int exp_done, input int exp_pass);
        min_cost        = 10'(mc);
        match_count     = 4'(cnt);
        exp_min_cost    = 10'(emc);
        exp_match_count = 4'(ecnt);
        valid           = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        check({tag, "_done"},    int'(done),    exp_done);
        check({tag, "_pass"},    int'(pass),    exp_pass);
        check({tag, "_serving"}, int'(serving), 1);
    endtask

    initial begin
        rst_n           = 1'b1;
        ld_valid        = 1'b0;
        ld_data         = '0;
        w               = '0;
        j               = '0;
        valid           = 1'b0;
        min_cost        = '0;
        match_count     = '0;
        exp_min_cost    = '0;
        exp_match_count = '0;

        apply_reset();

        // Gapped k mod 100 load with a stray Valid on beat 30.
        fill_mod100();
        load_matrix(1'b1, 30, -1);
        read_cost(3'd0, 3'd0);
        read_cost(3'd0, 3'd1);
        read_cost(3'd7, 3'd7);
        random_reads(12);
        check("no_capture_in_load", int'(done), 0);

        // Reset while serving, then a load cut short by reset at beat 40.
        apply_reset();
        fill_random();
        load_matrix(1'b0, -1, 40);
        check("abort_ld_ready", int'(ld_ready), 1);
        check("abort_serving",  int'(serving),  0);

        // A full 64-beat reload with fresh data must land from index 0.
        fill_random();
        load_matrix(1'b1, -1, -1);
        random_reads(16);

        // Matching result; a later mismatching Valid must not re-capture.
        check("pre_valid_done", int'(done), 0);
        pulse_valid("match", 12, 2, 12, 2, 1, 1);
        random_reads(6);
        pulse_valid("recapture_bad", 13, 3, 12, 2, 1, 1);

        // Match count off by one; a later correct Valid must not re-capture.
        apply_reset();
        fill_mod100();
        load_matrix(1'b0, -1, -1);
        pulse_valid("cnt_mismatch", 12, 3, 12, 2, 1, 0);
        pulse_valid("recapture_good", 12, 2, 12, 2, 1, 0);
        read_cost(3'd7, 3'd7);

        // Differences only in the top bit of each field.
        apply_reset();
        fill_random();
        load_matrix(1'b1, -1, -1);
        pulse_valid("min_msb", 524, 2, 12, 2, 1, 0);

        apply_reset();
        load_matrix(1'b0, -1, -1);
        pulse_valid("cnt_msb", 12, 10, 12, 2, 1, 0);

        // All-ones on both fields must still match exactly.
        apply_reset();
        load_matrix(1'b0, -1, -1);
        pulse_valid("full_scale", 1023, 15, 1023, 15, 1, 1);
        random_reads(4);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Backstop in case a DUT fault stalls a bounded loop indefinitely.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
